// File: rtl/axis_cic_decimator.sv
// CIC decimator: N integrators at the input rate, decimate by R, N combs (M=1) at the output rate.
// The output is the full-width, unscaled result; DC gain is R^N.
module axis_cic_decimator #(
  parameter int IN_WIDTH  = 16,
  parameter int R         = 100,
  parameter int N         = 1,
  parameter int CIC_WIDTH = IN_WIDTH + N*$clog2(R) + 1
) (
  input  logic                        aclk,
  input  logic                        arst_n,
  input  logic signed [IN_WIDTH-1:0]  s_axis_data_tdata,
  input  logic                        s_axis_data_tvalid,
  output logic                        s_axis_data_tready,
  output logic signed [CIC_WIDTH-1:0] m_axis_data_tdata,
  output logic                        m_axis_data_tvalid
);

  localparam int CNT_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

  logic                 tready_r;
  logic                 accept_s;
  logic [CIC_WIDTH-1:0] in_ext_s;
  logic [CIC_WIDTH-1:0] int_r  [N];
  logic [CIC_WIDTH-1:0] comb_r [N];
  logic [CIC_WIDTH-1:0] dly_r  [N];
  logic [CNT_W-1:0]     cnt_r;
  logic                 dec_stb_r;
  logic                 m_tvalid_r;

  // Handshake qualification and sign extension of the incoming sample.
  always_comb begin
    accept_s = s_axis_data_tvalid & tready_r;
    in_ext_s = {{(CIC_WIDTH-IN_WIDTH){s_axis_data_tdata[IN_WIDTH-1]}}, s_axis_data_tdata};
  end

  // Ready is held low only while in reset; there is no input-side backpressure.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      tready_r <= 1'b0;
    end else begin
      tready_r <= 1'b1;
    end
  end

  // Integrator chain at the input rate; plain modulo arithmetic, wrap-around is intended.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N; i++) begin
        int_r[i] <= {CIC_WIDTH{1'b0}};
      end
    end else if (accept_s) begin
      int_r[0] <= int_r[0] + in_ext_s;
      for (int i = 1; i < N; i++) begin
        int_r[i] <= int_r[i] + int_r[i-1];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int_r[i] <= int_r[i];
      end
    end
  end

  // Decimation counter: counts accepted samples, strobes once per R of them.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      dec_stb_r <= 1'b0;
    end else if (accept_s) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r     <= {CNT_W{1'b0}};
        dec_stb_r <= 1'b1;
      end else begin
        cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        dec_stb_r <= 1'b0;
      end
    end else begin
      cnt_r     <= cnt_r;
      dec_stb_r <= 1'b0;
    end
  end

  // Comb chain at the output rate. The last integrator is read before this edge's
  // accumulate, so an accept coinciding with the strobe lands in the next frame.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N; i++) begin
        comb_r[i] <= {CIC_WIDTH{1'b0}};
        dly_r[i]  <= {CIC_WIDTH{1'b0}};
      end
    end else if (dec_stb_r) begin
      comb_r[0] <= int_r[N-1] - dly_r[0];
      dly_r[0]  <= int_r[N-1];
      for (int i = 1; i < N; i++) begin
        comb_r[i] <= comb_r[i-1] - dly_r[i];
        dly_r[i]  <= comb_r[i-1];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        comb_r[i] <= comb_r[i];
        dly_r[i]  <= dly_r[i];
      end
    end
  end

  // Output valid is the strobe delayed to line up with the final comb register.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= dec_stb_r;
    end
  end

  assign s_axis_data_tready = tready_r;
  assign m_axis_data_tdata  = comb_r[N-1];
  assign m_axis_data_tvalid = m_tvalid_r;

endmodule

// File: tb/tb_axis_cic_decimator.sv
// Directed bench for axis_cic_decimator at IN_WIDTH=16, R=100, N=1 (24-bit output).
module tb_axis_cic_decimator;

  logic               aclk;
  logic               arst_n;
  logic signed [15:0] s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  logic signed [23:0] m_tdata;
  logic               m_tvalid;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  axis_cic_decimator #(
    .IN_WIDTH (16),
    .R        (100),
    .N        (1),
    .CIC_WIDTH(24)
  ) dut (
    .aclk              (aclk),
    .arst_n            (arst_n),
    .s_axis_data_tdata (s_tdata),
    .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tready(s_tready),
    .m_axis_data_tdata (m_tdata),
    .m_axis_data_tvalid(m_tvalid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps negedges until an output pulse (or the limit); optionally toggles tvalid every cycle.
  task automatic wait_pulse(input bit gap, input int limit, output int cycles, output logic signed [63:0] data);
    cycles = 0;
    do begin
      if (gap) s_tvalid = ~s_tvalid;
      @(negedge aclk);
      cycles++;
    end while (!m_tvalid && cycles < limit);
    check("pulse_seen", 64'(m_tvalid), 64'sd1);
    data = 64'(m_tdata);
  endtask

  initial begin
    int cyc;
    int pulses;
    int drops;
    logic signed [63:0] val;

    arst_n   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 16'sd0;
    repeat (3) @(negedge aclk);
    check("rst_tready", 64'(s_tready), 64'sd0);
    check("rst_tvalid", 64'(m_tvalid), 64'sd0);
    check("rst_tdata",  64'(m_tdata),  64'sd0);

    arst_n = 1'b1;
    #1;
    check("tready_before_edge", 64'(s_tready), 64'sd0);
    @(negedge aclk);
    check("tready_after_edge", 64'(s_tready), 64'sd1);

    pulses = 0;
    drops  = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge aclk);
      if (m_tvalid) pulses++;
      if (!s_tready) drops++;
    end
    check("idle_pulses", 64'(pulses), 64'sd0);
    check("idle_tready_drops", 64'(drops), 64'sd0);

    // DC gain: 1000 * 100
    s_tdata  = 16'sd1000;
    s_tvalid = 1'b1;
    wait_pulse(1'b0, 300, cyc, val);
    check("dc_first_latency", 64'(cyc), 64'sd101);
    check("dc_first_value", val, 64'sd100000);
    @(negedge aclk);
    check("dc_pulse_width", 64'(m_tvalid), 64'sd0);
    check("dc_hold", 64'(m_tdata), 64'sd100000);
    wait_pulse(1'b0, 300, cyc, val);
    check("dc_period_after_hold", 64'(cyc), 64'sd99);
    check("dc_value", val, 64'sd100000);
    for (int k = 0; k < 2; k++) begin
      wait_pulse(1'b0, 300, cyc, val);
      check("dc_period", 64'(cyc), 64'sd100);
      check("dc_value", val, 64'sd100000);
    end

    // Negative full scale; the sample taken in the strobe cycle still belongs to the old value.
    s_tdata = -16'sd32768;
    wait_pulse(1'b0, 300, cyc, val);
    check("neg_transient", val, -64'sd3243032);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(1'b0, 300, cyc, val);
      check("neg_period", 64'(cyc), 64'sd100);
      check("neg_value", val, -64'sd3276800);
    end

    s_tdata = 16'sd0;
    wait_pulse(1'b0, 300, cyc, val);
    check("zero_transient", val, -64'sd32768);
    wait_pulse(1'b0, 300, cyc, val);
    check("zero_settled", val, 64'sd0);

    // Positive full scale long enough for the integrator to wrap several times.
    s_tdata = 16'sd32767;
    wait_pulse(1'b0, 300, cyc, val);
    check("wrap_transient", val, 64'sd3243933);
    for (int k = 0; k < 20; k++) begin
      wait_pulse(1'b0, 300, cyc, val);
      check("wrap_value", val, 64'sd3276700);
    end

    // Gapped valid: spacing follows accepted samples, not cycles.
    s_tdata = 16'sd1000;
    wait_pulse(1'b1, 500, cyc, val);
    check("gap_transient", val, 64'sd131767);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(1'b1, 500, cyc, val);
      check("gap_period", 64'(cyc), 64'sd200);
      check("gap_value", val, 64'sd100000);
    end

    // Reset in the middle of a frame discards the partial frame.
    s_tdata  = 16'sd500;
    s_tvalid = 1'b1;
    repeat (57) @(negedge aclk);
    #2;
    arst_n = 1'b0;
    #1;
    check("midrst_tready", 64'(s_tready), 64'sd0);
    check("midrst_tvalid", 64'(m_tvalid), 64'sd0);
    check("midrst_tdata",  64'(m_tdata),  64'sd0);
    @(negedge aclk);
    arst_n = 1'b1;
    wait_pulse(1'b0, 300, cyc, val);
    check("midrst_latency", 64'(cyc), 64'sd102);
    check("midrst_value", val, 64'sd50000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
